// File: rtl/serial_tx.sv
// Byte-serial UART transmitter: 8N1/8N2 frames, LSB first, fixed clocks per bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit (8E1/8E2).
module serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       txDone,
  output logic       txd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] BCNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  logic [2:0]  r_state;
  logic [7:0]  r_shift;
  logic [15:0] r_bcnt;
  logic [2:0]  r_bit_idx;
  logic        r_stop_idx;
  logic        r_txd;
  logic        r_busy;
  logic        r_done;
`ifdef SERIAL_TX_PARITY_EN
  logic        r_par;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_bcnt == BCNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'd0;
      r_bcnt     <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      // The baud counter only runs while a frame is in flight and wraps at every bit boundary.
      if (r_state != S_IDLE) begin
        r_bcnt <= w_bit_end ? 16'd0 : r_bcnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (txStart) begin
            r_shift    <= txData;
            r_busy     <= 1'b1;
            r_txd      <= 1'b0;
            r_bcnt     <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= r_par ^ r_shift[0];
`endif
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
              r_txd   <= r_par;
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
`ifdef SERIAL_TX_PARITY_EN
              r_par     <= r_par ^ r_shift[0];
`endif
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_idx == STOP_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_txd   <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign txd    = r_txd;
  assign txBusy = r_busy;
  assign txDone = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame-level model checked every cycle, plus a line receiver.
module tb_serial_tx;
  localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int          P      = 1;
  localparam logic [10:0] A5_SEQ = 11'b10101001010;
  localparam int          RUN1   = 44;
  localparam int          RUN2   = 48;
`else
  localparam int          P      = 0;
  localparam logic [10:0] A5_SEQ = 11'b01101001010;
  localparam int          RUN1   = 40;
  localparam int          RUN2   = 44;
`endif
  localparam int NB = 10 + P;

  logic clk, reset;
  logic start0, start2;
  logic [7:0] data0, data2;
  logic txd0, busy0, done0, txd2, busy2, done2;

  serial_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .txStart(start0), .txData(data0),
    .txBusy(busy0), .txDone(done0), .txd(txd0));

  serial_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .txStart(start2), .txData(data2),
    .txBusy(busy2), .txDone(done2), .txd(txd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_cnt = 0;
  bit armed = 1'b0;
  logic [2:0] e0 = 3'b100;
  logic [2:0] e2 = 3'b100;
  logic [2:0] q0[$];
  logic [2:0] q2[$];
  logic [7:0] sent0[$];
  logic [7:0] rx0[$];
  int run0 = 0, run2 = 0, last_run0 = 0, last_run2 = 0, done_cnt0 = 0;
  int frame_err = 0;
  int acc_cyc0 = 0, acc_cyc2 = 0;

  typedef logic [2:0] oq_t[$];

  // Expected {txd,busy,done} for every cycle after the accepting edge.
  function automatic oq_t make_frame(input logic [7:0] d, input int stops);
    oq_t q;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(^d);
`endif
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < C; j++) q.push_back({bits[k], 2'b10});
    q.push_back(3'b101);
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired at cycle %0d", name, cyc);
  endtask

  // Model: one accepted byte becomes a queue of per-cycle outputs.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      q0.delete();
      q2.delete();
      e0 = 3'b100;
      e2 = 3'b100;
      rst_cnt++;
    end else begin
      if (q0.size() == 0) begin
        if (start0) begin
          q0 = make_frame(data0, 1);
          e0 = q0.pop_front();
        end else e0 = 3'b100;
      end else e0 = q0.pop_front();
      if (q2.size() == 0) begin
        if (start2) begin
          q2 = make_frame(data2, 2);
          e2 = q2.pop_front();
        end else e2 = 3'b100;
      end else e2 = q2.pop_front();
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("line0", {29'd0, txd0, busy0, done0}, {29'd0, e0});
      chk("line2", {29'd0, txd2, busy2, done2}, {29'd0, e2});
    end
  end

  initial forever begin
    @(negedge clk);
    if (busy0 === 1'b1) run0++;
    else begin
      if (run0 > 0) last_run0 = run0;
      run0 = 0;
    end
    if (busy2 === 1'b1) run2++;
    else begin
      if (run2 > 0) last_run2 = run2;
      run2 = 0;
    end
    if (done0 === 1'b1) done_cnt0++;
  end

  // Line receiver on dut: mid-bit sampling, frames cut by reset are discarded.
  initial forever begin
    @(negedge clk);
    if (armed && txd0 === 1'b0) begin
      int r0;
      logic [7:0] rb;
      bit ok;
      r0 = rst_cnt;
      ok = 1'b1;
      repeat (C / 2) @(negedge clk);
      if (txd0 !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        rb[i] = txd0;
      end
`ifdef SERIAL_TX_PARITY_EN
      repeat (C) @(negedge clk);
      if (txd0 !== ^rb) ok = 1'b0;
`endif
      repeat (C) @(negedge clk);
      if (txd0 !== 1'b1) ok = 1'b0;
      if (r0 == rst_cnt) begin
        rx0.push_back(rb);
        $display("rx0 frame byte=%02h framing_ok=%0d", rb, ok);
        if (!ok) frame_err++;
      end
    end
  end

  task automatic send0(input logic [7:0] d, input bit keep);
    int w;
    w = 0;
    while (busy0 !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) timeout("send0_wait");
    start0 = 1'b1;
    data0  = d;
    @(negedge clk);
    start0 = 1'b0;
    data0  = 8'($urandom);
    acc_cyc0 = cyc;
    if (keep) sent0.push_back(d);
    $display("tx0 send byte=%02h", d);
  endtask

  task automatic send2(input logic [7:0] d);
    int w;
    w = 0;
    while (busy2 !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) timeout("send2_wait");
    start2 = 1'b1;
    data2  = d;
    @(negedge clk);
    start2 = 1'b0;
    data2  = 8'($urandom);
    acc_cyc2 = cyc;
    $display("tx2 send byte=%02h", d);
  endtask

  task automatic wait_idle0();
    int w;
    w = 0;
    while (busy0 !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) timeout("idle0_wait");
  endtask

  task automatic wait_idle2();
    int w;
    w = 0;
    while (busy2 !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) timeout("idle2_wait");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] seq;
    int base_done;
    int t;
    int n;
    seq = '0;
    reset = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    data0 = 8'd0;
    data2 = 8'd0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    chk("rst_txd", {31'd0, txd0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_txd", {31'd0, txd0}, 32'd1);

    // Single byte 0xA5 with literal bit pattern and busy length.
    base_done = done_cnt0;
    send0(8'hA5, 1'b1);
    repeat (C / 2) @(negedge clk);
    seq[0] = txd0;
    for (int k = 1; k < NB; k++) begin
      repeat (C) @(negedge clk);
      seq[k] = txd0;
    end
    chk("a5_bits", {21'd0, seq}, {21'd0, A5_SEQ});
    wait_idle0();
    @(negedge clk);
    chk("a5_busy_len", last_run0, RUN1);
    chk("a5_done_pulses", done_cnt0 - base_done, 1);

    // Back-to-back: accepts are one frame plus one clock apart.
    send0(8'h00, 1'b1);
    t = acc_cyc0;
    send0(8'hFF, 1'b1);
    chk("b2b_spacing", acc_cyc0 - t, RUN1 + 1);

    // Start pulse mid-frame must be ignored.
    send0(8'h55, 1'b1);
    repeat (15) @(negedge clk);
    start0 = 1'b1;
    data0 = 8'h3C;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle0();
    repeat (60) @(negedge clk);
    chk("ignored_no_frame", {31'd0, busy0}, 32'd0);

    // Reset during data bit 3 of 0x0F.
    send0(8'h0F, 1'b0);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_txd", {31'd0, txd0}, 32'd1);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_done", {31'd0, done0}, 32'd0);
    repeat (50) @(negedge clk);

    // Reset and start together: byte dropped.
    reset = 1'b1;
    start0 = 1'b1;
    data0 = 8'hE7;
    @(negedge clk);
    reset = 1'b0;
    start0 = 1'b0;
    chk("rst_start_busy", {31'd0, busy0}, 32'd0);
    send0(8'h81, 1'b1);

    // Firmware version reply then histogram burst through the write loop.
    send0(8'h17, 1'b1);
    for (int i = 0; i < 136; i++) send0(8'((i * 37 + 11) & 255), 1'b1);
    wait_idle0();
    repeat (3 * C) @(negedge clk);

    // Two stop bits.
    send2(8'h17);
    wait_idle2();
    @(negedge clk);
    chk("stop2_busy_len", last_run2, RUN2);
    send2(8'hC3);
    t = acc_cyc2;
    send2(8'h3C);
    chk("stop2_spacing", acc_cyc2 - t, RUN2 + 1);
    wait_idle2();
    repeat (5) @(negedge clk);

    chk("rx_count", rx0.size(), sent0.size());
    n = (rx0.size() < sent0.size()) ? rx0.size() : sent0.size();
    for (int i = 0; i < n; i++) chk($sformatf("rx_byte%0d", i), {24'd0, rx0[i]}, {24'd0, sent0[i]});
    chk("rx_framing", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
